multicycle_datapath: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle load/store/ALU datapath.

---
 rtl/multicycle_datapath.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle load/store/ALU datapath sequenced DECODE/EXEC/MEM/WB
// Optional build macro: STATUS_FLAGS_EN adds registered zero/carry/overflow outputs.
module multicycle_datapath #(
  parameter int WIDTH     = 32,
  parameter int NREGS     = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int RA = $clog2(NREGS),
  localparam int MA = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             ready,
  input  logic [RA-1:0]    rs,
  input  logic [RA-1:0]    rt,
  input  logic [RA-1:0]    rd,
  input  logic [15:0]      imm16,
  input  logic             RegWr,
  input  logic             RegDst,
  input  logic             ALUSrc,
  input  logic [2:0]       ALUCntrl,
  input  logic             MemWr,
  input  logic             MemToReg,
  output logic             done,
`ifdef STATUS_FLAGS_EN
  output logic             zero,
  output logic             carry,
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  state_t           state_q;
  logic             ready_q, done_q;
  logic [WIDTH-1:0] result_q;

  // Instruction fields captured at accept; the live inputs are don't-care afterwards.
  logic [RA-1:0]    rs_q, rt_q, rd_q;
  logic [15:0]      imm_q;
  logic             regwr_q, regdst_q, alusrc_q, memwr_q, memtoreg_q;
  logic [2:0]       aluctl_q;

  // Registered intermediates between the stages.
  logic [WIDTH-1:0] a_q, b_q, aluout_q, mdr_q;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] mem_q  [MEM_DEPTH];

  logic [WIDTH-1:0] sext_imm, op_b, add_b, alu_res, wdata;
  logic [WIDTH:0]   add_full;
  logic             is_sub, is_addsub, add_ovf, slt_lt;
  logic [RA-1:0]    waddr;
  logic [MA-1:0]    mem_idx;

  // ALU, write-back mux and address decode on the registered operands.
  always_comb begin
    sext_imm  = {{(WIDTH-16){imm_q[15]}}, imm_q};
    op_b      = alusrc_q ? b_q : sext_imm;
    is_sub    = (aluctl_q == OP_SUB);
    is_addsub = (aluctl_q == OP_ADD) || is_sub;
    // Subtraction reuses the adder as A + ~B + 1 so carry means "no borrow".
    add_b     = is_sub ? ~op_b : op_b;
    add_full  = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
    add_ovf   = (a_q[WIDTH-1] == add_b[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
    slt_lt    = ($signed(a_q) < $signed(op_b));
    alu_res   = '0;
    unique case (aluctl_q)
      OP_ADD, OP_SUB: alu_res = add_full[WIDTH-1:0];
      OP_XOR:         alu_res = a_q ^ op_b;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_AND:         alu_res = a_q & op_b;
      OP_NAND:        alu_res = ~(a_q & op_b);
      OP_NOR:         alu_res = ~(a_q | op_b);
      OP_OR:          alu_res = a_q | op_b;
      default:        alu_res = '0;
    endcase
    wdata   = memtoreg_q ? mdr_q : aluout_q;
    waddr   = regdst_q ? rd_q : rt_q;
    // Byte address, word aligned; bits above the memory size are dropped so it wraps.
    mem_idx = aluout_q[MA+1:2];
  end

  // Sequencer: one instruction at a time, done/result registered on the way back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      result_q   <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      regwr_q    <= 1'b0;
      regdst_q   <= 1'b0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= '0;
      memwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      aluout_q   <= '0;
      mdr_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            rs_q       <= rs;
            rt_q       <= rt;
            rd_q       <= rd;
            imm_q      <= imm16;
            regwr_q    <= RegWr;
            regdst_q   <= RegDst;
            alusrc_q   <= ALUSrc;
            aluctl_q   <= ALUCntrl;
            memwr_q    <= MemWr;
            memtoreg_q <= MemToReg;
            ready_q    <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= regs_q[rs_q];
          b_q     <= regs_q[rt_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          aluout_q <= alu_res;
          if (memwr_q || memtoreg_q) begin
            state_q <= S_MEM;
          end else if (regwr_q) begin
            state_q <= S_WB;
          end else begin
            result_q <= alu_res;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_MEM: begin
          // Nonblocking read alongside the store: a combined op sees the old word.
          if (memtoreg_q) mdr_q <= mem_q[mem_idx];
          if (regwr_q) begin
            state_q <= S_WB;
          end else begin
            result_q <= aluout_q;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_WB: begin
          result_q <= wdata;
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: cleared by reset, written in WB; register 0 is never written so it reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_WB && regwr_q && waddr != '0) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Data memory: not reset; an async reset forces IDLE first, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (state_q == S_MEM && memwr_q) mem_q[mem_idx] <= b_q;
  end

`ifdef STATUS_FLAGS_EN
  logic zero_q, carry_q, ovf_q;

  // Status flags captured from the ALU in EXEC and held until the next EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == S_EXEC) begin
      zero_q  <= (alu_res == '0);
      carry_q <= is_addsub && add_full[WIDTH];
      ovf_q   <= is_addsub && add_ovf;
    end
  end

  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
`endif

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed vector bench for multicycle_datapath
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        ready;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        RegWr, RegDst, ALUSrc, MemWr, MemToReg;
  logic [2:0]  ALUCntrl;
  logic        done;
  logic [31:0] result;
`ifdef STATUS_FLAGS_EN
  logic        zero, carry, overflow;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        regwr, regdst, alusrc;
    logic [2:0]  ctl;
    logic        memwr, memtoreg;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  multicycle_datapath dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .RegWr(RegWr), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUCntrl(ALUCntrl),
    .MemWr(MemWr), .MemToReg(MemToReg), .done(done),
`ifdef STATUS_FLAGS_EN
    .zero(zero), .carry(carry), .overflow(overflow),
`endif
    .result(result)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int a, input int b, input int c, input logic [15:0] imm,
                              input logic wr, input logic dst, input logic src, input logic [2:0] ctl,
                              input logic mw, input logic m2r, input logic [31:0] exp, input int lat);
    vec_t v;
    v.rs = 5'(a); v.rt = 5'(b); v.rd = 5'(c); v.imm = imm;
    v.regwr = wr; v.regdst = dst; v.alusrc = src; v.ctl = ctl;
    v.memwr = mw; v.memtoreg = m2r; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    rs = v.rs; rt = v.rt; rd = v.rd; imm16 = v.imm;
    RegWr = v.regwr; RegDst = v.regdst; ALUSrc = v.alusrc; ALUCntrl = v.ctl;
    MemWr = v.memwr; MemToReg = v.memtoreg;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cnt);
    cnt = 1;
    while (!done && cnt < 30) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int cnt;
    issue(v);
    wait_done(cnt);
    chk({nm, "_lat"}, 32'(cnt), 32'(v.lat));
    chk({nm, "_res"}, result, v.exp);
  endtask

  initial begin
    int   cnt;
    logic saw_done;
    vec_t v;

    // rs rt rd imm wr dst src ctl mw m2r exp lat
    vecs[0]  = mk(0, 1, 0, 16'h0005, 1, 0, 0, 3'b000, 0, 0, 32'h0000_0005, 4);
    vecs[1]  = mk(1, 2, 0, 16'hFFFF, 1, 0, 0, 3'b000, 0, 0, 32'h0000_0004, 4);
    vecs[2]  = mk(2, 1, 3, 16'h0000, 1, 1, 1, 3'b011, 0, 0, 32'h0000_0001, 4);
    vecs[3]  = mk(2, 1, 6, 16'h0000, 1, 1, 1, 3'b001, 0, 0, 32'hFFFF_FFFF, 4);
    vecs[4]  = mk(1, 6, 7, 16'h0000, 1, 1, 1, 3'b010, 0, 0, 32'hFFFF_FFFA, 4);
    vecs[5]  = mk(7, 8, 0, 16'h00FF, 1, 0, 0, 3'b100, 0, 0, 32'h0000_00FA, 4);
    vecs[6]  = mk(1, 2, 9, 16'h0000, 1, 1, 1, 3'b101, 0, 0, 32'hFFFF_FFFB, 4);
    vecs[7]  = mk(1, 10, 0, 16'h0002, 1, 0, 0, 3'b110, 0, 0, 32'hFFFF_FFF8, 4);
    vecs[8]  = mk(1, 8, 11, 16'h0000, 1, 1, 1, 3'b111, 0, 0, 32'h0000_00FF, 4);
    vecs[9]  = mk(6, 1, 14, 16'h0000, 1, 1, 1, 3'b011, 0, 0, 32'h0000_0001, 4);
    vecs[10] = mk(1, 6, 15, 16'h0000, 1, 1, 1, 3'b011, 0, 0, 32'h0000_0000, 4);
    vecs[11] = mk(0, 1, 0, 16'h0008, 0, 0, 0, 3'b000, 1, 0, 32'h0000_0008, 4);
    vecs[12] = mk(0, 4, 0, 16'h0008, 1, 0, 0, 3'b000, 0, 1, 32'h0000_0005, 5);
    vecs[13] = mk(0, 12, 0, 16'h1008, 1, 0, 0, 3'b000, 0, 1, 32'h0000_0005, 5);
    vecs[14] = mk(4, 13, 0, 16'h0000, 1, 0, 0, 3'b000, 0, 0, 32'h0000_0005, 4);
    vecs[15] = mk(1, 0, 0, 16'h0003, 0, 0, 0, 3'b000, 0, 0, 32'h0000_0008, 3);
    vecs[16] = mk(0, 0, 0, 16'h0007, 1, 0, 0, 3'b000, 0, 0, 32'h0000_0007, 4);
    vecs[17] = mk(0, 5, 0, 16'h0000, 1, 0, 0, 3'b000, 0, 0, 32'h0000_0000, 4);
    vecs[18] = mk(0, 2, 16, 16'h0008, 1, 1, 0, 3'b000, 1, 1, 32'h0000_0005, 5);
    vecs[19] = mk(0, 17, 0, 16'h0008, 1, 0, 0, 3'b000, 0, 1, 32'h0000_0004, 5);
    vecs[20] = mk(0, 0, 0, 16'h0008, 0, 0, 0, 3'b000, 0, 1, 32'h0000_0008, 4);
    vecs[21] = mk(16, 18, 0, 16'h0000, 1, 0, 0, 3'b000, 0, 0, 32'h0000_0005, 4);

    reset_n = 1'b0; start = 1'b0;
    rs = '0; rt = '0; rd = '0; imm16 = '0;
    RegWr = 0; RegDst = 0; ALUSrc = 0; ALUCntrl = '0; MemWr = 0; MemToReg = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
`ifdef STATUS_FLAGS_EN
    chk("rst_flags", {29'd0, zero, carry, overflow}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // start while busy must be ignored
    issue(mk(1, 19, 0, 16'h000A, 1, 0, 0, 3'b000, 0, 0, 32'd15, 4));
    @(negedge clk);
    chk("busy_ready", 32'(ready), 32'd0);
    rt = 5'd20; imm16 = 16'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cnt);
    chk("busy_done_seen", 32'(done), 32'd1);
    chk("busy_res", result, 32'd15);
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    chk("busy_no_extra_done", 32'(saw_done), 32'd0);
    run_vec("busy_r20", mk(20, 21, 0, 16'h0000, 1, 0, 0, 3'b000, 0, 0, 32'd0, 4));

    // reset during MEM of a store
    run_vec("pre_store", mk(0, 1, 0, 16'h0010, 0, 0, 0, 3'b000, 1, 0, 32'h10, 4));
    issue(mk(0, 2, 0, 16'h0010, 0, 0, 0, 3'b000, 1, 0, 32'h10, 4));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec("abort_mem", mk(0, 1, 0, 16'h0010, 1, 0, 0, 3'b000, 0, 1, 32'd5, 5));
    run_vec("abort_regs", mk(2, 3, 0, 16'h0000, 1, 0, 0, 3'b000, 0, 0, 32'd0, 4));

`ifdef STATUS_FLAGS_EN
    run_vec("f_seed", mk(0, 20, 0, 16'h4000, 1, 0, 0, 3'b000, 0, 0, 32'h4000, 4));
    for (int k = 0; k < 17; k++) begin
      v = mk(20, 20, 20, 16'h0000, 1, 1, 1, 3'b000, 0, 0, 32'h4000 << (k + 1), 4);
      run_vec($sformatf("f_dbl%0d", k), v);
    end
    run_vec("f_max", mk(20, 20, 0, 16'hFFFF, 1, 0, 0, 3'b000, 0, 0, 32'h7FFF_FFFF, 4));
    chk("f_max_cv", {30'd0, carry, overflow}, 32'b11);
    run_vec("f_ovf", mk(20, 21, 0, 16'h0001, 1, 0, 0, 3'b000, 0, 0, 32'h8000_0000, 4));
    chk("f_ovf_zcv", {29'd0, zero, carry, overflow}, 32'b001);
    run_vec("f_sub", mk(20, 20, 22, 16'h0000, 1, 1, 1, 3'b001, 0, 0, 32'h0, 4));
    chk("f_sub_zcv", {29'd0, zero, carry, overflow}, 32'b110);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
